// File: rtl/mining_pkg.sv
// Shared constants, transmit state encoding and frame byte selection for
// the golden-nonce report path.
package mining_pkg;

  localparam int NONCE_W = 32;
  localparam int FRAME_LEN = 6;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_B3,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_CSUM
  } tx_state_e;

  // Byte on the link for a given state; IDLE parks the bus at zero.
  function automatic logic [7:0] frame_byte(input tx_state_e st,
                                            input logic [NONCE_W-1:0] n,
                                            input logic [7:0] sync);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      ST_SYNC: b = sync;
      ST_B3:   b = n[31:24];
      ST_B2:   b = n[23:16];
      ST_B1:   b = n[15:8];
      ST_B0:   b = n[7:0];
      ST_CSUM: b = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Small circular FIFO with a registered occupancy count; the head word is
// read combinationally so the consumer can latch it on the pop edge.
module nonce_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// Queues golden nonces from the miner core and streams each one to the host
// as a six-byte frame: sync, nonce MSB first, XOR checksum.
module golden_nonce_tx
  import mining_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] NONCE_OFFSET = 32'd0,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                   hash_clk,
  input  logic                   reset,
  input  logic                   nonce_valid,
  input  logic [NONCE_W-1:0]     golden_nonce,
  input  logic                   clear_overflow,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  tx_state_e          state_q, state_d;
  logic [NONCE_W-1:0] frame_q, frame_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               overflow_q, overflow_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;
  logic [NONCE_W-1:0] fifo_rdata;
  logic [NONCE_W-1:0] adj_nonce;

  assign adj_nonce = golden_nonce - NONCE_OFFSET;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk   (hash_clk),
    .rst_n (reset),
    .push  (fifo_push),
    .wdata (adj_nonce),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // tx_data is computed from the next state so it is already registered
  // when tx_valid rises and cannot change while a byte is stalled.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = ST_SYNC;
      end
      ST_SYNC: if (tx_ready) state_d = ST_B3;
      ST_B3:   if (tx_ready) state_d = ST_B2;
      ST_B2:   if (tx_ready) state_d = ST_B1;
      ST_B1:   if (tx_ready) state_d = ST_B0;
      ST_B0:   if (tx_ready) state_d = ST_CSUM;
      ST_CSUM: if (tx_ready) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SYNC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_d    = fifo_pop ? fifo_rdata : frame_q;
    tx_data_d  = frame_byte(state_d, frame_d, SYNC_BYTE);
    fifo_push  = nonce_valid && (!fifo_full || fifo_pop);
    drop       = nonce_valid && fifo_full && !fifo_pop;
    overflow_d = drop || (overflow_q && !clear_overflow);
  end

  always_ff @(posedge hash_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q != ST_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Directed bench for golden_nonce_tx: framing, offsets, backpressure,
// overflow handling, same-cycle push/pop and asynchronous reset.
module tb_golden_nonce_tx;
  import mining_pkg::*;

  localparam int DEPTH = 4;

  logic        hash_clk;
  logic        reset;
  logic        nv0, nv1, nv2;
  logic [31:0] golden_nonce;
  logic        clear_overflow;
  logic        tx_ready;

  logic [7:0]  data0, data1, data2;
  logic        valid0, valid1, valid2;
  logic [2:0]  cnt0, cnt1, cnt2;
  logic        ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic [7:0] obs_data;
  logic       obs_valid;

  golden_nonce_tx #(.DEPTH(DEPTH), .NONCE_OFFSET(32'd0)) dut0 (
    .hash_clk(hash_clk), .reset(reset), .nonce_valid(nv0),
    .golden_nonce(golden_nonce), .clear_overflow(clear_overflow),
    .tx_data(data0), .tx_valid(valid0), .tx_ready(tx_ready),
    .fifo_count(cnt0), .overflow(ovf0));

  golden_nonce_tx #(.DEPTH(DEPTH), .NONCE_OFFSET(32'd1)) dut1 (
    .hash_clk(hash_clk), .reset(reset), .nonce_valid(nv1),
    .golden_nonce(golden_nonce), .clear_overflow(clear_overflow),
    .tx_data(data1), .tx_valid(valid1), .tx_ready(tx_ready),
    .fifo_count(cnt1), .overflow(ovf1));

  golden_nonce_tx #(.DEPTH(DEPTH), .NONCE_OFFSET(32'd2)) dut2 (
    .hash_clk(hash_clk), .reset(reset), .nonce_valid(nv2),
    .golden_nonce(golden_nonce), .clear_overflow(clear_overflow),
    .tx_data(data2), .tx_valid(valid2), .tx_ready(tx_ready),
    .fifo_count(cnt2), .overflow(ovf2));

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  always_comb begin
    obs_data  = data0;
    obs_valid = valid0;
    case (sel)
      1: begin obs_data = data1; obs_valid = valid1; end
      2: begin obs_data = data2; obs_valid = valid2; end
      default: begin obs_data = data0; obs_valid = valid0; end
    endcase
  end

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Walks one frame with tx_ready high, starting at the SYNC byte.
  task automatic check_bytes(input int dsel, input string tag,
                             input logic [7:0] b [FRAME_LEN]);
    sel = dsel;
    #0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      check_output($sformatf("%s valid[%0d]", tag, i), 32'(obs_valid), 32'd1);
      check_output($sformatf("%s byte[%0d]", tag, i), 32'(obs_data), 32'(b[i]));
      tick();
    end
    sel = 0;
  endtask

  function automatic void model_frame(input logic [31:0] n,
                                      output logic [7:0] b [FRAME_LEN]);
    b[0] = 8'hA5;
    b[1] = n[31:24];
    b[2] = n[23:16];
    b[3] = n[15:8];
    b[4] = n[7:0];
    b[5] = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
  endfunction

  task automatic check_frame(input int dsel, input string tag, input logic [31:0] n);
    logic [7:0] b [FRAME_LEN];
    model_frame(n, b);
    check_bytes(dsel, tag, b);
  endtask

  task automatic strobe0(input logic [31:0] n);
    golden_nonce = n;
    nv0 = 1'b1;
    tick();
    nv0 = 1'b0;
  endtask

  initial begin
    logic [7:0] fa [FRAME_LEN];
    logic [7:0] fb [FRAME_LEN];
    logic [7:0] bp [FRAME_LEN];
    int k;

    reset = 1'b0;
    nv0 = 1'b0; nv1 = 1'b0; nv2 = 1'b0;
    golden_nonce = 32'h0;
    clear_overflow = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();

    check_output("reset tx_valid", 32'(valid0), 32'd0);
    check_output("reset tx_data", 32'(data0), 32'h00);
    check_output("reset fifo_count", 32'(cnt0), 32'd0);
    check_output("reset overflow", 32'(ovf0), 32'd0);
    reset = 1'b1;
    tick();
    tick();

    // Single hit: A5 0E 33 33 7A 74.
    strobe0(32'h0e33337a);
    check_output("hit count N+1", 32'(cnt0), 32'd1);
    check_output("hit valid N+1", 32'(valid0), 32'd0);
    tick();
    check_output("hit count N+2", 32'(cnt0), 32'd0);
    fa = '{8'hA5, 8'h0E, 8'h33, 8'h33, 8'h7A, 8'h74};
    check_bytes(0, "hit", fa);
    check_output("hit idle N+8", 32'(valid0), 32'd0);

    // Offset 2 turns 0e33337c into the same frame.
    golden_nonce = 32'h0e33337c;
    nv2 = 1'b1;
    tick();
    nv2 = 1'b0;
    tick();
    check_bytes(2, "off2", fa);
    check_output("off2 idle", 32'(valid2), 32'd0);

    // Offset 1 wraps zero to all ones.
    golden_nonce = 32'h00000000;
    nv1 = 1'b1;
    tick();
    nv1 = 1'b0;
    tick();
    fb = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    check_bytes(1, "off1", fb);
    check_output("off1 idle", 32'(valid1), 32'd0);

    // Backpressure with tx_ready pattern 1,0,0,1.
    strobe0(32'h12345678);
    tick();
    model_frame(32'h12345678, bp);
    k = 0;
    for (int c = 0; c < 40 && k < FRAME_LEN; c++) begin
      tx_ready = (c % 4 == 0) || (c % 4 == 3);
      check_output($sformatf("bp valid c%0d", c), 32'(valid0), 32'd1);
      check_output($sformatf("bp byte c%0d", c), 32'(data0), 32'(bp[k]));
      tick();
      if (tx_ready) k++;
    end
    check_output("bp bytes done", k, FRAME_LEN);
    tx_ready = 1'b1;
    check_output("bp idle", 32'(valid0), 32'd0);

    // Overflow: six strobes with the link stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      golden_nonce = 32'(i);
      nv0 = 1'b1;
      tick();
    end
    nv0 = 1'b0;
    check_output("ovf count", 32'(cnt0), 32'd4);
    check_output("ovf flag", 32'(ovf0), 32'd1);
    check_output("ovf sync held", 32'(data0), 32'hA5);
    tx_ready = 1'b1;
    for (int i = 1; i <= 5; i++) check_frame(0, $sformatf("drain%0d", i), 32'(i));
    check_output("drain idle", 32'(valid0), 32'd0);
    check_output("drain flag held", 32'(ovf0), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_output("ovf cleared", 32'(ovf0), 32'd0);

    // Full FIFO accepts a strobe on the CSUM handshake.
    tx_ready = 1'b0;
    for (int i = 10; i <= 14; i++) begin
      golden_nonce = 32'(i);
      nv0 = 1'b1;
      tick();
    end
    nv0 = 1'b0;
    check_output("full count", 32'(cnt0), 32'd4);
    tx_ready = 1'b1;
    repeat (5) tick();
    check_output("at csum", 32'(data0), 32'h0A);
    golden_nonce = 32'd15;
    nv0 = 1'b1;
    tick();
    nv0 = 1'b0;
    check_output("pushpop overflow", 32'(ovf0), 32'd0);
    check_output("pushpop count", 32'(cnt0), 32'd4);
    check_output("pushpop sync", 32'(data0), 32'hA5);

    // Drop and clear in the same cycle: set wins.
    tx_ready = 1'b0;
    golden_nonce = 32'd16;
    nv0 = 1'b1;
    clear_overflow = 1'b1;
    tick();
    nv0 = 1'b0;
    clear_overflow = 1'b0;
    check_output("set wins", 32'(ovf0), 32'd1);
    check_output("set wins count", 32'(cnt0), 32'd4);

    reset = 1'b0;
    #1;
    check_output("rst1 overflow", 32'(ovf0), 32'd0);
    check_output("rst1 count", 32'(cnt0), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Reset during B2 with two entries queued.
    strobe0(32'h00C0FFEE);
    strobe0(32'd1);
    strobe0(32'd2);
    check_output("mid count", 32'(cnt0), 32'd2);
    tx_ready = 1'b1;
    tick();
    tick();
    check_output("mid b2", 32'(data0), 32'hC0);
    reset = 1'b0;
    #1;
    check_output("async tx_valid", 32'(valid0), 32'd0);
    check_output("async tx_data", 32'(data0), 32'h00);
    check_output("async count", 32'(cnt0), 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_output($sformatf("post rst quiet c%0d", c), 32'(valid0), 32'd0);
    end

    strobe0(32'hDEADBEEF);
    tick();
    check_frame(0, "post rst", 32'hDEADBEEF);
    check_output("final idle", 32'(valid0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/golden_nonce_tx.md
# golden_nonce_tx

Sits between the miner core's golden-nonce output and the host link, facing the opposite direction to work loading. Each reported golden nonce is queued in a small FIFO, corrected for pipeline lag, and sent as a framed byte stream on a valid/ready byte interface toward the UART/host transmitter. No nonce is lost silently: overflow is flagged and held until the host clears it.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- NONCE_OFFSET, 32'd0: value subtracted (mod 2^32) from each reported nonce before queuing.
- SYNC_BYTE, 8'hA5: first byte of every frame.

- hash_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset); deassertion is synchronised externally.
- nonce_valid  in  1  single-cycle strobe: golden_nonce holds a hit.
- golden_nonce  in  32  raw nonce from the miner core.
- clear_overflow  in  1  clears the overflow flag.
- tx_data  out  8  byte being offered.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  consumer accepts; a byte transfers when tx_valid && tx_ready.
- fifo_count  out  $clog2(DEPTH)+1  entries queued, excluding the frame in flight.
- overflow  out  1  sticky; set when a nonce is dropped.

## Operation
- Push: on nonce_valid, golden_nonce − NONCE_OFFSET (32-bit wrap) is written if count < DEPTH, or if count == DEPTH and a pop happens in the same cycle. Otherwise the nonce is dropped and overflow is set.
- Frame: 6 bytes: SYNC_BYTE, N[31:24], N[23:16], N[15:8], N[7:0], CSUM. CSUM = XOR of the four nonce bytes.
- States: IDLE, SYNC, B3, B2, B1, B0, CSUM.
  - IDLE: if the FIFO is not empty, pop into the 32-bit frame register and go to SYNC. tx_valid = 0 in IDLE.
  - SYNC through B0: advance only on handshake.
  - CSUM: on handshake, pop and go to SYNC if the FIFO is not empty, else go to IDLE.
- tx_valid = 1 in every state except IDLE. tx_data is a registered function of state and the frame register, so it stays stable while tx_valid && !tx_ready.
- Overflow and clear_overflow:
  - clear_overflow with no drop in the same cycle clears overflow.
  - A drop in the same cycle as clear_overflow leaves overflow = 1 (set wins).
- Reset at any point, including mid-frame: the FIFO empties, the frame in flight is abandoned without a partial CSUM, and state returns to IDLE.

## Timing
- Reset values: tx_valid = 0, tx_data = 8'h00, fifo_count = 0, overflow = 0, state IDLE, FIFO pointers 0.
- With the FIFO empty and in IDLE: strobe at cycle N, fifo_count = 1 at N+1, tx_valid = 1 with SYNC_BYTE at N+2, fifo_count = 0 at N+2.
- With tx_ready held high, a frame takes exactly 6 cycles. Back-to-back frames have no idle cycle between CSUM and the next SYNC.
- Throughput is bounded by one frame per 6 cycles. Strobes arriving faster fill the FIFO.
- Pop and push in the same cycle: fifo_count is unchanged.

## Structure
- Package mining_pkg holds:
  - SYNC_BYTE default.
  - FRAME_LEN = 6.
  - The tx state enum.
  - The nonce width constant (32).
- Sub-module nonce_fifo: parameterised depth and width; registered count; push, pop and full/empty logic; first-word fall-through not required.
- The top level holds the offset subtractor, the FSM and the overflow flag.

## Test plan
- Single hit, NONCE_OFFSET=0, nonce 32'h0e33337a, tx_ready=1 -> bytes A5 0E 33 33 7A 74 on cycles N+2 to N+7; tx_valid low at N+8.
- NONCE_OFFSET=2, strobe 32'h0e33337c -> same frame as above. NONCE_OFFSET=1, strobe 32'h00000000 -> nonce bytes FF FF FF FF, CSUM 00.
- Backpressure: tx_ready toggles 1,0,0,1,... during a frame -> tx_data/tx_valid stable during stalls; byte order and CSUM unchanged; no duplicated or skipped bytes.
- Overflow, DEPTH=4, tx_ready=0: 6 consecutive strobes with nonces 1..6 ->
  - nonce 1 goes into the frame register and nonces 2–5 are queued, so fifo_count = 4.
  - nonce 6 is dropped and overflow = 1.
  - Raising tx_ready delivers frames for nonces 1–5 back-to-back, with no idle cycles.
  - Pulsing clear_overflow then gives overflow = 0.
- Simultaneous events:
  - With fifo_count = DEPTH, a strobe in the same cycle as the CSUM handshake is accepted; overflow stays 0 and fifo_count is unchanged.
  - A strobe and clear_overflow in the same cycle with the FIFO full leaves overflow = 1.
- Reset asserted during byte B2 of a frame, with 2 entries queued -> outputs return to reset values immediately (asynchronously). After release, no bytes are emitted until a new strobe arrives.
